full_adder_seq_n: RTL and testbench

//   Parametrised multi-cycle adder: computes S = A + B + cin over WIDTH/CHUNK

---
 rtl/full_adder_seq_n.sv | 100 ++++++++++
 tb/tb_full_adder_seq_n.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/full_adder_seq_n.sv
// Multi-cycle adder: sums WIDTH-bit operands CHUNK bits per clock with a registered
// ripple carry. The result registers hold their value until the next completion.
`timescale 1ns / 1ps

module full_adder_seq_n #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] outS,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNTW-1:0] LastCnt = CNTW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic             carry_q;
  logic [CNTW-1:0]  cnt_q;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] s_chunk;
  logic             c_chunk;
  logic             ovf_d;
  int unsigned      lo;

  // One chunk of the ripple add, merged into the partial sum so the final
  // chunk can be committed to outS in the same edge that computes it.
  always_comb begin
    lo      = int'(cnt_q) * CHUNK;
    a_chunk = a_q[lo +: CHUNK];
    b_chunk = b_q[lo +: CHUNK];
    {c_chunk, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    sum_d            = sum_q;
    sum_d[lo +: CHUNK] = s_chunk;
    ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      outS    <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= inA;
            b_q     <= inB;
            carry_q <= cin;
            cnt_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          sum_q   <= sum_d;
          carry_q <= c_chunk;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            outS    <= sum_d;
            cout    <= c_chunk;
            ovf     <= ovf_d;
            state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_full_adder_seq_n.sv
// Bench for full_adder_seq_n at CHUNK = 4, 16 and 1 (WIDTH = 16), scoreboard-checked.
`timescale 1ns / 1ps

module tb_full_adder_seq_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  start;
  logic [15:0] inA;
  logic [15:0] inB;
  logic        cin;
  logic        busy_w [3];
  logic        done_w [3];
  logic        cout_w [3];
  logic        ovf_w  [3];
  logic [15:0] outS_w [3];

  int checks   = 0;
  int failures = 0;
  int nch[3]   = '{4, 1, 16};

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  exp_t last_r [3];

  full_adder_seq_n #(.WIDTH(16), .CHUNK(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .inA(inA), .inB(inB), .cin(cin),
    .busy(busy_w[0]), .done(done_w[0]), .outS(outS_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0])
  );
  full_adder_seq_n #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .inA(inA), .inB(inB), .cin(cin),
    .busy(busy_w[1]), .done(done_w[1]), .outS(outS_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1])
  );
  full_adder_seq_n #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .inA(inA), .inB(inB), .cin(cin),
    .busy(busy_w[2]), .done(done_w[2]), .outS(outS_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] t;
    exp_t r;
    t    = {1'b0, a} + {1'b0, b} + {16'd0, c};
    r.s  = t[15:0];
    r.co = t[16];
    r.ov = (a[15] == b[15]) && (t[15] != a[15]);
    return r;
  endfunction

  task automatic check_zero_state();
    for (int d = 0; d < 3; d++) begin
      check("rst_busy", 32'(busy_w[d]), 0);
      check("rst_done", 32'(done_w[d]), 0);
      check("rst_outS", 32'(outS_w[d]), 0);
      check("rst_cout", 32'(cout_w[d]), 0);
      check("rst_ovf", 32'(ovf_w[d]), 0);
      last_r[d] = '0;
    end
  endtask

  // One operation on DUT d; with disturb set, inputs churn and start is held
  // through RUN and DONE, which must not affect the captured operation.
  task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input bit disturb);
    int   lat;
    exp_t e;
    inA      = a;
    inB      = b;
    cin      = c;
    start[d] = 1'b1;
    sb.push_back(model(a, b, c));
    @(posedge clk); #1;
    start[d] = 1'b0;
    lat      = 0;
    while (done_w[d] !== 1'b1 && lat < 40) begin
      check("busy_run", 32'(busy_w[d]), 1);
      check("hold_outS_run", 32'(outS_w[d]), 32'(last_r[d].s));
      if (disturb) begin
        inA      = 16'($urandom);
        inB      = 16'($urandom);
        cin      = 1'($urandom);
        start[d] = 1'b1;
      end
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, nch[d]);
    check("busy_at_done", 32'(busy_w[d]), 0);
    e = sb.pop_front();
    check("outS", 32'(outS_w[d]), 32'(e.s));
    check("cout", 32'(cout_w[d]), 32'(e.co));
    check("ovf", 32'(ovf_w[d]), 32'(e.ov));
    last_r[d] = e;
    @(posedge clk); #1;
    start[d] = 1'b0;
    check("done_one_cycle", 32'(done_w[d]), 0);
    check("idle_after_done", 32'(busy_w[d]), 0);
    if (disturb) begin
      @(posedge clk); #1;
      check("start_not_queued", 32'(busy_w[d]), 0);
      check("hold_outS_idle", 32'(outS_w[d]), 32'(e.s));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = '0;
    inA   = '0;
    inB   = '0;
    cin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_state();
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0);
    run_op(0, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run_op(0, 16'h8000, 16'h8000, 1'b0, 1'b0);
    run_op(0, 16'h1234, 16'h4321, 1'b1, 1'b1);

    // Reset during the second RUN cycle aborts without a done pulse.
    inA      = 16'h0F0F;
    inB      = 16'h00FF;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_zero_state();
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("no_done_after_abort", 32'(done_w[0]), 0);
    run_op(0, 16'h0F0F, 16'h00FF, 1'b1, 1'b0);

    run_op(1, 16'hA5A5, 16'h5A5B, 1'b0, 1'b0);
    run_op(2, 16'hA5A5, 16'h5A5B, 1'b0, 1'b0);
    run_op(1, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1);
    run_op(2, 16'h8001, 16'hFFFF, 1'b0, 1'b1);

    for (int i = 0; i < 1000; i++)
      run_op(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    for (int i = 0; i < 100; i++) begin
      run_op(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
      run_op(2, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
